// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port (req/lock/addr/wstrb/wdata in, gnt/rvalid/rdata out); master = requester side, slave = arbiter side
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic req;
  logic lock;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0] wstrb;
  logic [DATA_WIDTH-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master(output req, lock, addr, wstrb, wdata, input gnt, rvalid, rdata);
  modport slave(input req, lock, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with bounded lock sharing one memory; ports clk, rst, requesters m0/m1, memory mem_en/mem_addr/mem_wstrb/mem_wdata/mem_rdata
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave m0,
  mem_arbiter_if.slave m1,
  output logic mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state;
  logic owner, last, pend, pown;
  logic [CW-1:0] cnt;
  logic [1:0] blk;
  logic g0, g1, gid, glock, olock;
  // grants are gated by rst so nothing is granted while reset is held
  always_comb begin
    g0 = !rst && m0.req && (state == LOCKED ? !owner : (!m1.req || last));
    g1 = !rst && m1.req && (state == LOCKED ? owner : (!m0.req || !last));
    gid = g1;
    glock = gid ? m1.lock : m0.lock;
    olock = owner ? m1.lock : m0.lock;
  end
  assign m0.gnt = g0;
  assign m1.gnt = g1;
  assign mem_en = g0 | g1;
  assign mem_addr = g1 ? m1.addr : g0 ? m0.addr : '0;
  assign mem_wstrb = g1 ? m1.wstrb : g0 ? m0.wstrb : '0;
  assign mem_wdata = g1 ? m1.wdata : g0 ? m0.wdata : '0;
  assign m0.rvalid = pend & !pown;
  assign m1.rvalid = pend & pown;
  assign m0.rdata = mem_rdata;
  assign m1.rdata = mem_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNLOCKED;
      owner <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      blk <= '0;
      pend <= 1'b0;
      pown <= 1'b0;
    end else begin
      pend <= mem_en && mem_wstrb == '0;
      pown <= gid;
      if (mem_en) last <= gid;
      blk <= blk & {m1.lock, m0.lock};
      if (state == UNLOCKED) begin
        if (mem_en && glock && !blk[gid]) begin
          state <= LOCKED;
          owner <= gid;
          cnt <= CW'(1);
        end
      end else if (!olock) begin
        state <= UNLOCKED;
        cnt <= '0;
      end else if (cnt == CW'(LOCK_MAX)) begin
        // forced release: owner loses the next tie and may not relock until it drops lock
        state <= UNLOCKED;
        cnt <= '0;
        last <= owner;
        blk[owner] <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port data memory between the core's load/store path (master 0) and a loader/debug requester (master 1). Grants are combinational, so the single-cycle core proceeds in the same cycle it wins. State covers a round-robin pointer, a bounded bus lock for multi-beat sequences, and a one-deep read-response tracker that steers synchronous memory read data back to its owner.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- mN_req  in  1  request, N∈{0,1}
- mN_lock  in  1  request to hold the bus after this grant
- mN_addr  in  ADDR_WIDTH  byte address
- mN_wstrb  in  4  byte write strobes; 0 means read
- mN_wdata  in  DATA_WIDTH  write data
- mN_gnt  out  1  request accepted this cycle (combinational)
- mN_rvalid  out  1  read data valid, one cycle after a read grant
- mN_rdata  out  DATA_WIDTH  equals mem_rdata
- mem_en  out  1  memory access this cycle
- mem_addr, mem_wstrb, mem_wdata  out  ADDR_WIDTH/4/DATA_WIDTH  muxed from the granted master; 0 when idle
- mem_rdata  in  DATA_WIDTH  valid the cycle after mem_en with mem_wstrb==0

## Operation
- Registered state: lock state (UNLOCKED/LOCKED), lock owner, 1-bit last-granted pointer, lock counter of width clog2(LOCK_MAX+1), relock-block flags (one per master), read-pending flag and owner.
- UNLOCKED arbitration:
  - One requester: it is granted.
  - Both requesting: the master that is not `last` is granted.
  - `last` updates to the granted master on every grant.
- Lock entry: if a master is granted in UNLOCKED with mN_lock=1 and its block flag clear, the next state is LOCKED, owner=N, counter=1.
- LOCKED:
  - Only the owner can be granted, and only when it requests.
  - The other master is not granted even if the owner is idle.
  - The counter increments every LOCKED cycle.
- Lock exit, evaluated each LOCKED cycle:
  - Owner lock=0: UNLOCKED next cycle. The current-cycle grant still goes to the owner if it requests.
  - Counter==LOCK_MAX while owner lock=1: forced release. UNLOCKED next cycle, `last`=owner (the other master wins the next tie), and the owner's block flag is set.
- A block flag clears in the cycle its master drives lock=0. While the flag is set, that master is granted normally but cannot re-lock.
- Read tracking:
  - A grant with wstrb==0 sets the pending flag and owner.
  - The next cycle, mN_rvalid=1 for that owner only, for exactly one cycle.
  - Write grants produce no rvalid.
  - Back-to-back reads give back-to-back rvalid pulses.
- mem_en=m0_gnt|m1_gnt. Grants are mutually exclusive (never both high).

## Timing
- Grant latency: 0 cycles, combinational from req, lock state, and `last`.
- Read data: mN_rvalid and mN_rdata arrive on the cycle after the grant edge.
- A write takes effect at the grant cycle's clock edge.
- Reset (rst=1, asynchronous):
  - Registers: UNLOCKED, last=1 (m0 wins the first tie), counter=0, block flags=0, pending=0.
  - Outputs: mN_gnt=0, mem_en=0, mN_rvalid=0.
- Reset mid-lock or with a read pending: the lock is dropped and the pending rvalid is suppressed. The first cycle after deassertion arbitrates from the reset state.
- Simultaneous owner lock=0 and counter==LOCK_MAX: treated as a normal release; no block flag is set.
- A requester granted with lock=1 while in LOCKED (the owner) stays locked; lock is not re-entered and the counter is not reset.
- LOCK_MAX=1: LOCKED lasts exactly one cycle, then forced release.

## Test plan
- Reset and idle:
  - Drive rst=1 with m0_req=m1_req=1 → both gnt=0, mem_en=0.
  - Release rst → m0 granted first cycle, m1 second, alternating thereafter.
- Single read: m1 reads addr 0x40, memory returns 0xDEADBEEF → m1_gnt at cycle T, m1_rvalid=1 with rdata=0xDEADBEEF at T+1, m0_rvalid=0 throughout.
- Write: m0 write with wstrb=4'b0011, data 0x1234 → mem_en=1, mem_wstrb=0011 in the grant cycle, no rvalid afterward.
- Voluntary lock:
  - m1 locks for 3 cycles with m0 requesting continuously → m0_gnt=0 for those cycles.
  - m1 drops lock → m0 granted the following cycle.
- Forced release (LOCK_MAX=4): m0 holds lock=1 and req=1 continuously, m1 requesting →
  - m0 granted 4 LOCKED cycles, then m1 granted.
  - Arbitration then alternates; m0 does not re-lock until it pulses lock=0.
- Async reset mid-lock: assert rst between clock edges during a locked read → rvalid never asserts, and post-reset arbitration restarts with m0 winning the tie.
